// File: rtl/reset_seq.sv
// Power-on reset sequencer: filters the raw PLL lock, waits DELAY cycles after
// the PLL is stable, then releases CHANNELS active-low resets in index order,
// STAGGER cycles apart. A one-cycle sw_reset_req in RUN re-runs the release.
// Optional feature: define RESET_SEQ_LOCKLOSS_EN to pull every channel back
// into reset when the filtered lock drops after leaving WAIT.
module reset_seq #(
  parameter int unsigned LOCK_FILTER = 4,
  parameter int unsigned DELAY       = 128,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned STAGGER     = 16
) (
  input  logic                clk_core,
  input  logic                dtr,
  input  logic                pll_locked,
  input  logic                sw_reset_req,
  output logic [CHANNELS-1:0] core_reset_n,
  output logic                pll_stable,
  output logic                seq_done
);

  localparam int unsigned CntMax = (DELAY > STAGGER) ? DELAY : STAGGER;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DelayVal   = CntW'(DELAY);
  localparam logic [CntW-1:0] StaggerVal = CntW'(STAGGER);

  typedef enum logic [1:0] {
    StWait,
    StCount,
    StStagger,
    StRun
  } state_e;

  state_e               state;
  logic [CntW-1:0]      cnt;
  logic [LOCK_FILTER-1:0] window;

  // Widened shift helpers so LOCK_FILTER = 1 and CHANNELS = 1 need no special case
  logic [LOCK_FILTER:0] window_ext;
  logic [CHANNELS:0]    release_ext;
  logic [CHANNELS-1:0]  release_next;
  logic                 lock_lost;

  // Next window contents and the reset vector with one more channel released
  always_comb begin
    window_ext   = {window, pll_locked};
    release_ext  = {core_reset_n, 1'b1};
    release_next = release_ext[CHANNELS-1:0];
  end

`ifdef RESET_SEQ_LOCKLOSS_EN
  assign lock_lost = ~pll_stable;
`else
  assign lock_lost = 1'b0;
`endif

  // Lock filter: pll_locked is sampled directly, stable only after a full window of ones
  always_ff @(posedge clk_core or negedge dtr) begin
    if (!dtr) begin
      window     <= '0;
      pll_stable <= 1'b0;
    end else begin
      window     <= window_ext[LOCK_FILTER-1:0];
      pll_stable <= &window;
    end
  end

  // Release sequencer: one shared counter, cleared on every match so it never wraps
  always_ff @(posedge clk_core or negedge dtr) begin
    if (!dtr) begin
      state        <= StWait;
      cnt          <= '0;
      core_reset_n <= '0;
      seq_done     <= 1'b0;
    end else begin
      unique case (state)
        StWait: begin
          core_reset_n <= '0;
          seq_done     <= 1'b0;
          if (pll_stable) begin
            state <= StCount;
            cnt   <= '0;
          end
        end
        StCount: begin
          if (lock_lost) begin
            state        <= StWait;
            cnt          <= '0;
            core_reset_n <= '0;
            seq_done     <= 1'b0;
          end else if (cnt == DelayVal) begin
            core_reset_n <= release_next;
            cnt          <= '0;
            // Single-channel builds go straight to RUN
            if (release_next[CHANNELS-1]) begin
              state    <= StRun;
              seq_done <= 1'b1;
            end else begin
              state <= StStagger;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStagger: begin
          if (lock_lost) begin
            state        <= StWait;
            cnt          <= '0;
            core_reset_n <= '0;
            seq_done     <= 1'b0;
          end else if (cnt == StaggerVal) begin
            core_reset_n <= release_next;
            cnt          <= '0;
            if (release_next[CHANNELS-1]) begin
              state    <= StRun;
              seq_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRun: begin
          // Lock loss wins over a simultaneous software request
          if (lock_lost) begin
            state        <= StWait;
            cnt          <= '0;
            core_reset_n <= '0;
            seq_done     <= 1'b0;
          end else if (sw_reset_req) begin
            state        <= StCount;
            cnt          <= '0;
            core_reset_n <= '0;
            seq_done     <= 1'b0;
          end
        end
        default: begin
          state        <= StWait;
          cnt          <= '0;
          core_reset_n <= '0;
          seq_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 4: consecutive pll_locked samples required before the PLL counts as stable (range 1..16).
REQ-002 SHALL have parameter DELAY, default 128: clk_core cycles from PLL stable to release of channel 0 (range 1..65535).
REQ-003 SHALL have parameter CHANNELS, default 3: number of independent reset outputs, released in index order (range 1..8).
REQ-004 SHALL have parameter STAGGER, default 16: cycles between successive channel releases (range 1..65535).
REQ-005 SHALL have port clk_core, input, 1: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port dtr, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: raw PLL LOCK, asynchronous to clk_core, sampled directly.
REQ-008 SHALL have port sw_reset_req, input, 1: one-cycle request to re-run the release sequence.
REQ-009 SHALL have port core_reset_n, output, CHANNELS: per-channel active-low reset, registered.
REQ-010 SHALL have port pll_stable, output, 1: filtered lock status, registered.
REQ-011 SHALL have port seq_done, output, 1: high when every channel is released.

Function
REQ-012 SHALL shift pll_locked into a LOCK_FILTER-bit window each cycle; pll_stable <= AND of the window (registered).
REQ-013 SHALL implement states WAIT, COUNT, STAGGER, RUN, with a single counter of width clog2(max(DELAY,STAGGER)+1).
REQ-014 WAIT: all core_reset_n low; on an edge with pll_stable=1 -> COUNT, counter <= 0.
REQ-015 COUNT: counter increments each cycle; on the edge where counter==DELAY, core_reset_n[0] <= 1, counter <= 0, and the state moves to STAGGER, or to RUN if CHANNELS==1.
REQ-016 STAGGER: counter increments; on the edge where counter==STAGGER, the next channel is released and the counter cleared; after release of channel CHANNELS-1 -> RUN.
REQ-017 Once released, a channel SHALL stay high until dtr, lock loss (REQ-023) or sw_reset_req; channels are never released out of order.
REQ-018 seq_done SHALL be registered and rise on the same edge as the last channel release; low in every state except RUN.
REQ-019 sw_reset_req=1 in RUN: next edge drives all core_reset_n low, seq_done low, counter <= 0, state -> COUNT (lock wait skipped).
REQ-020 sw_reset_req SHALL be ignored in WAIT, COUNT and STAGGER; a sequence in progress is not restarted.
REQ-021 The counter SHALL never wrap; the comparison values are constants and the counter clears on every match.

Reset
REQ-022 dtr=0 SHALL immediately force state WAIT, counter 0, window 0, pll_stable 0, core_reset_n all 0, seq_done 0, regardless of clock; after dtr rises, operation restarts from REQ-012 and any sequence interrupted mid-way is discarded.

Configuration
REQ-023 Macro RESET_SEQ_LOCKLOSS_EN defined: pll_stable=0 in COUNT, STAGGER or RUN SHALL, on the next edge, drive all core_reset_n low and seq_done low and return to WAIT; lock loss takes priority over a simultaneous sw_reset_req.
REQ-024 Macro not defined: after leaving WAIT, pll_stable SHALL be ignored and released channels stay high through lock loss; pll_stable is still reported.

Verification
REQ-025 Defaults; dtr high, pll_locked high from edge E1 -> pll_stable at E5, COUNT at E6, core_reset_n[0] at E135, [1] at E152, [2] and seq_done at E169.
REQ-026 pll_locked toggles every 3 cycles for 100 cycles (LOCK_FILTER=4) -> pll_stable stays 0 and core_reset_n stays 3'b000 throughout.
REQ-027 Pulse sw_reset_req for one cycle at E200 in RUN -> core_reset_n=000 at E201, re-release at E330, E347, E364; a pulse at E300 (in COUNT) has no effect.
REQ-028 dtr low for 2 ns at E150 (mid-STAGGER) -> outputs 0 asynchronously; full sequence restarts from lock filter after dtr rises.
REQ-029 With RESET_SEQ_LOCKLOSS_EN: drop pll_locked at E180 (in RUN) -> pll_stable 0 at E181, core_reset_n=000 and state WAIT at E182; without the macro, outputs stay 3'b111.
REQ-030 CHANNELS=1, DELAY=1 -> core_reset_n[0] and seq_done rise 2 edges after entering COUNT; the STAGGER state is never entered.
